// File: rtl/roulette_pkg.sv
// rtl/roulette_pkg.sv - shared states, opcodes and bet field layout for the roulette round controller
package roulette_pkg;

  typedef enum logic [1:0] {
    ST_BETTING,
    ST_SPINNING,
    ST_RESULT,
    ST_CLEAR
  } round_state_e;

  localparam logic [5:0] OPC_SPIN   = 6'h3E;
  localparam logic [5:0] OPC_NONE   = 6'h3F;
  localparam logic [5:0] WHEEL_IDLE = 6'd63;

  localparam int BET_OPC_LSB = 0;
  localparam int BET_OPC_W   = 6;
  localparam int BET_AMT_LSB = BET_OPC_LSB + BET_OPC_W;
  localparam int BET_AMT_W   = 2;

  // Keyboard control codes travel on the bet path but are never real bets.
  function automatic logic is_ctrl_opcode(input logic [BET_OPC_W-1:0] opc);
    return (opc == OPC_SPIN) || (opc == OPC_NONE);
  endfunction

endpackage

// File: rtl/wheel_settle_filter.sv
// rtl/wheel_settle_filter.sv - counts consecutive unchanged wheel_num cycles and flags a settled wheel
module wheel_settle_filter
  import roulette_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic [5:0] wheel_num_i,
  output logic       settled_o,
  output logic [5:0] value_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(SETTLE_CYCLES);

  logic [5:0]    prev_q;
  logic [CW-1:0] stab_q;
  logic [CW-1:0] stab_d;

  // stab_d already includes the current cycle's comparison, so settling is seen without extra lag.
  always_comb begin
    stab_d = '0;
    if (wheel_num_i == prev_q) begin
      stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      stab_q <= '0;
    end else if (clear_i) begin
      prev_q <= wheel_num_i;
      stab_q <= '0;
    end else begin
      prev_q <= wheel_num_i;
      stab_q <= stab_d;
    end
  end

  assign settled_o = (stab_d >= STAB_MAX);
  assign value_o   = prev_q;

endmodule

// File: rtl/roulette_round_ctrl.sv
// rtl/roulette_round_ctrl.sv - bet collection, wheel spin and result hold for one roulette round
// Optional ROUND_CTRL_BET_HOLD_EN stretches bet_received_o for HOLD_CYCLES after each accept.
module roulette_round_ctrl
  import roulette_pkg::*;
#(
  parameter int unsigned MAX_BETS        = 12,
  parameter int unsigned BET_W           = 8,
  parameter int unsigned SETTLE_CYCLES   = 1_000_000,
  parameter int unsigned MIN_SPIN_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bet_valid_i,
  input  logic [BET_W-1:0]          bet_data_i,
  output logic                      bet_ready_o,
  input  logic                      spin_req_i,
  input  logic [5:0]                wheel_num_i,
  input  logic                      round_done_i,
  output logic                      spin_active_o,
  output logic [3:0]                bet_count_o,
  output logic [MAX_BETS*BET_W-1:0] bets_flat_o,
  output logic                      bet_received_o,
  output logic [5:0]                result_num_o,
  output logic                      result_valid_o,
  output logic                      spin_timeout_o
);

  localparam int unsigned EW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [EW-1:0] MIN_SPIN = EW'(MIN_SPIN_CYCLES);
  localparam logic [EW-1:0] TIMEOUT  = EW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_BETS);

  round_state_e   state_q, state_d;
  logic [3:0]     count_q, count_d;
  logic           ready_q;
  logic [BET_W-1:0] bets_q [MAX_BETS];
  logic [EW-1:0]  elapsed_q;
  logic [5:0]     result_q;
  logic           result_valid_q;
  logic           timeout_q;
  logic           store, go_spin, capture, time_out;
  logic           settled;
  logic [5:0]     settle_value;

  wheel_settle_filter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (go_spin),
    .wheel_num_i (wheel_num_i),
    .settled_o   (settled),
    .value_o     (settle_value)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    store    = 1'b0;
    go_spin  = 1'b0;
    capture  = 1'b0;
    time_out = 1'b0;
    case (state_q)
      ST_BETTING: begin
        store = bet_valid_i && ready_q && !is_ctrl_opcode(bet_data_i[BET_OPC_LSB +: BET_OPC_W]);
        if (store) count_d = count_q + 1'b1;
        // The same-cycle bet counts toward the non-empty requirement.
        if (spin_req_i && (count_d != 4'd0)) begin
          go_spin = 1'b1;
          state_d = ST_SPINNING;
        end
      end
      ST_SPINNING: begin
        if ((elapsed_q >= MIN_SPIN) && settled && (settle_value != WHEEL_IDLE)) begin
          capture = 1'b1;
          state_d = ST_RESULT;
        end else if (elapsed_q == TIMEOUT) begin
          time_out = 1'b1;
          state_d  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (round_done_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        count_d = '0;
        state_d = ST_BETTING;
      end
      default: state_d = ST_BETTING;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_BETTING;
      count_q        <= '0;
      ready_q        <= 1'b0;
      elapsed_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= (state_d == ST_BETTING) && (count_d < MAX_CNT);
      if (go_spin) begin
        elapsed_q <= '0;
      end else if ((state_q == ST_SPINNING) && (elapsed_q != TIMEOUT)) begin
        elapsed_q <= elapsed_q + 1'b1;
      end
      if (capture) begin
        result_q       <= settle_value;
        result_valid_q <= 1'b1;
      end else if (time_out) begin
        result_q       <= WHEEL_IDLE;
        result_valid_q <= 1'b1;
        timeout_q      <= 1'b1;
      end else if (state_q == ST_CLEAR) begin
        result_q       <= '0;
        result_valid_q <= 1'b0;
        timeout_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_BETS); i++) bets_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int i = 0; i < int'(MAX_BETS); i++) bets_q[i] <= '0;
    end else if (store) begin
      for (int i = 0; i < int'(MAX_BETS); i++) begin
        if (count_q == 4'(i)) bets_q[i] <= bet_data_i;
      end
    end
  end

  for (genvar g = 0; g < int'(MAX_BETS); g++) begin : g_flat
    assign bets_flat_o[g*BET_W +: BET_W] = bets_q[g];
  end

`ifdef ROUND_CTRL_BET_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      hold_q <= '0;
    end else if (store) begin
      hold_q <= HW'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  assign bet_received_o = (hold_q != '0);
`else
  logic received_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) received_q <= 1'b0;
    else       received_q <= store;
  end

  assign bet_received_o = received_q;
`endif

  assign bet_ready_o    = ready_q;
  assign spin_active_o  = (state_q == ST_SPINNING);
  assign bet_count_o    = count_q;
  assign result_num_o   = result_q;
  assign result_valid_o = result_valid_q;
  assign spin_timeout_o = timeout_q;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// tb/tb_roulette_round_ctrl.sv - directed tables plus randomized model check of roulette_round_ctrl
module tb_roulette_round_ctrl;

  localparam int MAXB = 12;
  localparam int SETTLE = 4;
  localparam int MINSP = 10;
  localparam int TMO = 40;
  localparam int HOLD = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bet_valid = 1'b0;
  logic [7:0]  bet_data = '0;
  logic        bet_ready;
  logic        spin_req = 1'b0;
  logic [5:0]  wheel_num = '0;
  logic        round_done = 1'b0;
  logic        spin_active;
  logic [3:0]  bet_count;
  logic [MAXB*8-1:0] bets_flat;
  logic        bet_received;
  logic [5:0]  result_num;
  logic        result_valid;
  logic        spin_timeout;

  int n_checks = 0;
  int n_fail = 0;

  roulette_round_ctrl #(
    .MAX_BETS(MAXB), .BET_W(8), .SETTLE_CYCLES(SETTLE), .MIN_SPIN_CYCLES(MINSP),
    .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .bet_valid_i(bet_valid), .bet_data_i(bet_data),
    .bet_ready_o(bet_ready), .spin_req_i(spin_req), .wheel_num_i(wheel_num),
    .round_done_i(round_done), .spin_active_o(spin_active), .bet_count_o(bet_count),
    .bets_flat_o(bets_flat), .bet_received_o(bet_received), .result_num_o(result_num),
    .result_valid_o(result_valid), .spin_timeout_o(spin_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic [3:0] cnt;
    logic       rdy;
    logic       act;
  } vec_t;

  vec_t tbl [7];

  // Reference model: bets as a list, round phase, spin age and wheel sample history.
  logic [7:0] mq [$];
  logic [5:0] mhist [$];
  int         mph, mt, mhold;
  logic [5:0] mres;
  logic       mval, mtmo, mrcv;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bet_valid = 1'b0;
    spin_req = 1'b0;
    round_done = 1'b0;
  endtask

  task automatic do_reset(input logic verify);
    idle_inputs();
    reset = 1'b1;
    step();
    if (verify) begin
      check("rst_ready", bet_ready, 0);
      check("rst_active", spin_active, 0);
      check("rst_count", bet_count, 0);
      check("rst_flat", bets_flat, 0);
      check("rst_rcv", bet_received, 0);
      check("rst_num", result_num, 0);
      check("rst_valid", result_valid, 0);
      check("rst_tmo", spin_timeout, 0);
    end
    reset = 1'b0;
    step();
  endtask

  function automatic logic [MAXB*8-1:0] mflat();
    logic [MAXB*8-1:0] f = '0;
    for (int i = 0; i < mq.size(); i++) f[i*8 +: 8] = mq[i];
    return f;
  endfunction

  task automatic model_reset();
    mq.delete();
    mhist.delete();
    mph = 0; mt = 0; mhold = 0;
    mres = '0; mval = 1'b0; mtmo = 1'b0; mrcv = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    logic stored = 1'b0;
    int   run;
    case (mph)
      0: begin
        if (bet_valid && (mq.size() < MAXB) && bet_data[5:0] != 6'h3E && bet_data[5:0] != 6'h3F) begin
          mq.push_back(bet_data);
          stored = 1'b1;
        end
        if (spin_req && mq.size() >= 1) begin
          mph = 1; mt = 0;
          mhist.delete();
          mhist.push_back(wheel_num);
        end
      end
      1: begin
        mhist.push_back(wheel_num);
        run = 0;
        for (int k = mhist.size() - 1; k >= 0; k--) begin
          if (mhist[k] != wheel_num) break;
          run++;
        end
        if (mt >= MINSP && (run - 1) >= SETTLE && wheel_num != 6'd63) begin
          mres = wheel_num; mval = 1'b1; mph = 2;
        end else if (mt == TMO) begin
          mres = 6'd63; mval = 1'b1; mtmo = 1'b1; mph = 2;
        end else begin
          mt++;
        end
      end
      2: if (round_done) mph = 3;
      default: begin
        mq.delete();
        mres = '0; mval = 1'b0; mtmo = 1'b0; mph = 0;
        mhold = 0;
      end
    endcase
    mrcv = stored;
    if (stored) mhold = HOLD;
    else if (mhold > 0 && mph != 0) mhold--;
    else if (mhold > 0 && !stored) mhold--;
  endtask

  task automatic model_compare();
    check("m_ready", bet_ready, (mph == 0) && (mq.size() < MAXB));
    check("m_active", spin_active, mph == 1);
    check("m_count", bet_count, mq.size());
    check("m_flat", bets_flat, mflat());
    check("m_num", result_num, mres);
    check("m_valid", result_valid, mval);
    check("m_tmo", spin_timeout, mtmo);
`ifdef ROUND_CTRL_BET_HOLD_EN
    check("m_rcv", bet_received, mhold > 0);
`else
    check("m_rcv", bet_received, mrcv);
`endif
  endtask

  initial begin
    int highs;
    logic [5:0] w;

    tbl[0] = '{v:1'b0, d:8'h00, s:1'b1, cnt:4'd0, rdy:1'b1, act:1'b0};
    tbl[1] = '{v:1'b1, d:8'h45, s:1'b0, cnt:4'd1, rdy:1'b1, act:1'b0};
    tbl[2] = '{v:1'b1, d:8'h81, s:1'b0, cnt:4'd2, rdy:1'b1, act:1'b0};
    tbl[3] = '{v:1'b1, d:8'hC2, s:1'b0, cnt:4'd3, rdy:1'b1, act:1'b0};
    tbl[4] = '{v:1'b1, d:8'h7E, s:1'b0, cnt:4'd3, rdy:1'b1, act:1'b0};
    tbl[5] = '{v:1'b1, d:8'hBF, s:1'b0, cnt:4'd3, rdy:1'b1, act:1'b0};
    tbl[6] = '{v:1'b0, d:8'h00, s:1'b1, cnt:4'd3, rdy:1'b0, act:1'b1};

    do_reset(1'b1);
    check("post_rst_ready", bet_ready, 1);
    for (int i = 0; i < 7; i++) begin
      bet_valid = tbl[i].v; bet_data = tbl[i].d; spin_req = tbl[i].s;
      step();
      check($sformatf("tbl%0d_count", i), bet_count, tbl[i].cnt);
      check($sformatf("tbl%0d_ready", i), bet_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_active", i), spin_active, tbl[i].act);
    end
    idle_inputs();
    check("tbl_flat", bets_flat[23:0], 24'hC28145);

    // Fill past capacity: 13 offers, only 12 land.
    do_reset(1'b0);
    bet_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bet_data = 8'(i + 1);
      check($sformatf("fill_ready%0d", i), bet_ready, i < MAXB);
      step();
      check($sformatf("fill_count%0d", i), bet_count, (i + 1 > MAXB) ? MAXB : i + 1);
    end
    idle_inputs();
    check("fill_last", bets_flat[11*8 +: 8], 8'd12);
    check("fill_ready_low", bet_ready, 0);

    // Same-cycle bet and spin from empty, then settle timing and round_done.
    do_reset(1'b0);
    wheel_num = 6'd9;
    bet_valid = 1'b1; bet_data = 8'h05; spin_req = 1'b1;
    step();
    idle_inputs();
    check("same_count", bet_count, 1);
    check("same_active", spin_active, 1);
    for (int c = 1; c <= 16; c++) begin
      wheel_num = (c >= 12) ? 6'd17 : ((c % 2 == 1) ? 6'd5 : 6'd9);
      step();
      check($sformatf("settle_valid_c%0d", c), result_valid, c == 16);
    end
    check("settle_num", result_num, 17);
    check("settle_tmo", spin_timeout, 0);
    check("settle_active", spin_active, 0);
    check("result_frozen", bet_count, 1);
    round_done = 1'b1;
    step();
    round_done = 1'b0;
    step();
    check("clr_count", bet_count, 0);
    check("clr_valid", result_valid, 0);
    check("clr_num", result_num, 0);
    check("clr_flat", bets_flat, 0);
    check("clr_ready", bet_ready, 1);

    // Spin with count 0 is ignored; a stuck wheel times out.
    do_reset(1'b0);
    wheel_num = 6'd63;
    spin_req = 1'b1;
    step();
    check("empty_spin", spin_active, 0);
    spin_req = 1'b0; bet_valid = 1'b1; bet_data = 8'h01;
    step();
    bet_valid = 1'b0; spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      step();
      if (c >= 39) check($sformatf("tmo_valid_c%0d", c), result_valid, c == 41);
    end
    check("tmo_num", result_num, 63);
    check("tmo_flag", spin_timeout, 1);

    // Asynchronous reset mid-spin.
    do_reset(1'b0);
    wheel_num = 6'd3;
    bet_valid = 1'b1; bet_data = 8'h22; spin_req = 1'b1;
    step();
    idle_inputs();
    step(); step();
    check("mid_active_pre", spin_active, 1);
    #3 reset = 1'b1;
    #1;
    check("mid_active", spin_active, 0);
    check("mid_count", bet_count, 0);
    check("mid_flat", bets_flat, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    step();

    // Lone accept and the bet_received indicator.
    bet_valid = 1'b1; bet_data = 8'h10;
    step();
    bet_valid = 1'b0;
    check("rcv_first", bet_received, 1);
    highs = 0;
    for (int c = 0; c < 15; c++) begin
      if (bet_received) highs++;
      step();
    end
`ifdef ROUND_CTRL_BET_HOLD_EN
    check("rcv_len", highs, HOLD);
`else
    check("rcv_len", highs, 1);
`endif

    // Randomized rounds against the model.
    do_reset(1'b0);
    model_reset();
    w = 6'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) w = ($urandom_range(15) == 0) ? 6'd63 : 6'($urandom_range(62));
      wheel_num = w;
      bet_valid = ($urandom_range(1) == 1);
      bet_data = ($urandom_range(4) == 0) ? {2'($urandom_range(3)), 6'h3E + 6'($urandom_range(1))}
                                          : 8'($urandom_range(255));
      spin_req = (mph == 0) ? ($urandom_range(5) == 0) : ($urandom_range(9) == 0);
      round_done = (mph == 2) ? ($urandom_range(3) == 0) : ($urandom_range(9) == 0);
      model_step();
      step();
      model_compare();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
